// File: rtl/dq_pi_current_controller.sv
// Time-multiplexed PI current regulator for the d/q (and further) axes.
// One shared signed multiplier; conditional-integration anti-windup; output held until accepted.
//
// state | meaning
// IDLE  | waiting for measurement_valid
// ERR   | compute error of channel ch from the snapshots
// MUL_P | shared multiplier: kp * e
// MUL_I | shared multiplier: ki * e
// ACC   | integrate, shift, clamp, store result of channel ch
// OUT   | result presented, waiting for output_ready
module dq_pi_current_controller #(
   parameter int CHANNELS   = 2,
   parameter int DATA_WIDTH = 16,
   parameter int GAIN_WIDTH = 16,
   parameter int GAIN_SHIFT = 10,
   parameter int OUT_LIMIT  = 2047
) (
   input  logic                           clk,
   input  logic                           reset_n,
   input  logic                           fault,
   input  logic [CHANNELS*DATA_WIDTH-1:0] reference_data,
   input  logic                           reference_valid,
   input  logic [CHANNELS*DATA_WIDTH-1:0] measurement_data,
   input  logic                           measurement_valid,
   input  logic [GAIN_WIDTH-1:0]          param_kp,
   input  logic [GAIN_WIDTH-1:0]          param_ki,
   output logic [CHANNELS*DATA_WIDTH-1:0] output_data,
   output logic                           output_valid,
   input  logic                           output_ready,
   output logic [CHANNELS-1:0]            saturated,
   output logic                           busy,
   output logic                           overrun
);

   localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
   localparam int EW = DATA_WIDTH + 1;
   localparam int PW = GAIN_WIDTH + 1 + EW;
   localparam int IW = DATA_WIDTH + GAIN_SHIFT;
   localparam int SW = ((PW > IW) ? PW : IW) + 2;
   localparam logic signed [SW-1:0] I_LIM = SW'(OUT_LIMIT) <<< GAIN_SHIFT;
   localparam logic signed [SW-1:0] O_LIM = SW'(OUT_LIMIT);
   localparam logic [DATA_WIDTH-1:0] POS_D = DATA_WIDTH'(OUT_LIMIT);
   localparam logic [DATA_WIDTH-1:0] NEG_D = -POS_D;

   typedef enum logic [2:0] {IDLE, ERR, MUL_P, MUL_I, ACC, OUT} state_t;

   state_t state, nstate;
   logic [CW-1:0]                    ch;
   logic [CHANNELS*DATA_WIDTH-1:0]   ref_reg, ref_snap, meas_snap, res_buf, res_next;
   logic [CHANNELS-1:0]              sat_buf, sat_next;
   logic signed [EW-1:0]             e_reg, e_next;
   logic signed [PW-1:0]             p_reg, ki_e_reg, prod;
   logic signed [IW-1:0]             integ [CHANNELS];
   logic signed [DATA_WIDTH-1:0]     ref_k, meas_k;
   logic [GAIN_WIDTH-1:0]            gain_op;
   logic signed [SW-1:0]             ic_raw, ic, sum, u_raw;
   logic [DATA_WIDTH-1:0]            u_d;
   logic                             sat, hold, last;

   assign busy = (state != IDLE);

   always_comb begin
      nstate = state;
      case (state)
         IDLE:    if (measurement_valid) nstate = ERR;
         ERR:     nstate = MUL_P;
         MUL_P:   nstate = MUL_I;
         MUL_I:   nstate = ACC;
         ACC:     nstate = last ? OUT : ERR;
         OUT:     if (output_ready) nstate = IDLE;
         default: nstate = IDLE;
      endcase
      if (fault) nstate = IDLE;
   end

   always_comb begin
      ref_k   = ref_snap[ch*DATA_WIDTH +: DATA_WIDTH];
      meas_k  = meas_snap[ch*DATA_WIDTH +: DATA_WIDTH];
      e_next  = {ref_k[DATA_WIDTH-1], ref_k} - {meas_k[DATA_WIDTH-1], meas_k};
      gain_op = (state == MUL_I) ? param_ki : param_kp;
      prod    = $signed({1'b0, gain_op}) * e_reg;
      // The clamped candidate also feeds the output, so a pinned integrator reads back as the limit.
      ic_raw  = SW'(integ[ch]) + SW'(ki_e_reg);
      if (ic_raw > I_LIM)       ic = I_LIM;
      else if (ic_raw < -I_LIM) ic = -I_LIM;
      else                      ic = ic_raw;
      sum     = SW'(p_reg) + ic;
      u_raw   = sum >>> GAIN_SHIFT;
      sat     = (u_raw > O_LIM) || (u_raw < -O_LIM);
      u_d     = sat ? (u_raw[SW-1] ? NEG_D : POS_D) : u_raw[DATA_WIDTH-1:0];
      hold    = sat && (e_reg != '0) && (e_reg[EW-1] == u_raw[SW-1]);
      last    = (ch == CW'(CHANNELS-1));
      res_next = res_buf;
      res_next[ch*DATA_WIDTH +: DATA_WIDTH] = u_d;
      sat_next = sat_buf;
      sat_next[ch] = sat;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= nstate;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ch           <= '0;
         ref_reg      <= '0;
         ref_snap     <= '0;
         meas_snap    <= '0;
         res_buf      <= '0;
         sat_buf      <= '0;
         e_reg        <= '0;
         p_reg        <= '0;
         ki_e_reg     <= '0;
         output_data  <= '0;
         output_valid <= 1'b0;
         saturated    <= '0;
         overrun      <= 1'b0;
         for (int k = 0; k < CHANNELS; k++) integ[k] <= '0;
      end else begin
         if (reference_valid) ref_reg <= reference_data;
         overrun      <= measurement_valid & ~fault & (state != IDLE);
         output_valid <= (nstate == OUT);
         if (fault) begin
            ch          <= '0;
            output_data <= '0;
            saturated   <= '0;
            for (int k = 0; k < CHANNELS; k++) integ[k] <= '0;
         end else begin
            case (state)
               IDLE: if (measurement_valid) begin
                  ref_snap  <= ref_reg;
                  meas_snap <= measurement_data;
                  ch        <= '0;
               end
               ERR:   e_reg    <= e_next;
               MUL_P: p_reg    <= prod;
               MUL_I: ki_e_reg <= prod;
               ACC: begin
                  if (!hold) integ[ch] <= ic[IW-1:0];
                  res_buf <= res_next;
                  sat_buf <= sat_next;
                  if (last) begin
                     output_data <= res_next;
                     saturated   <= sat_next;
                     ch          <= '0;
                  end else begin
                     ch <= ch + CW'(1);
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_dq_pi_current_controller.sv
// Bench for dq_pi_current_controller: directed scenarios with literal results plus a
// randomized run, all compared each cycle against an arithmetic model of the regulator.
module tb_dq_pi_current_controller;

   localparam int CH  = 2;
   localparam int DW  = 16;
   localparam int GW  = 16;
   localparam int GS  = 10;
   localparam int OL  = 2047;
   localparam int LAT = 4*CH + 1;

   logic              clk, reset_n, fault;
   logic [CH*DW-1:0]  reference_data, measurement_data, output_data;
   logic              reference_valid, measurement_valid;
   logic [GW-1:0]     param_kp, param_ki;
   logic              output_valid, output_ready, busy, overrun;
   logic [CH-1:0]     saturated;

   int vectors = 0;
   int miscompares = 0;

   dq_pi_current_controller #(
      .CHANNELS(CH), .DATA_WIDTH(DW), .GAIN_WIDTH(GW), .GAIN_SHIFT(GS), .OUT_LIMIT(OL)
   ) dut (
      .clk(clk), .reset_n(reset_n), .fault(fault),
      .reference_data(reference_data), .reference_valid(reference_valid),
      .measurement_data(measurement_data), .measurement_valid(measurement_valid),
      .param_kp(param_kp), .param_ki(param_ki),
      .output_data(output_data), .output_valid(output_valid), .output_ready(output_ready),
      .saturated(saturated), .busy(busy), .overrun(overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input longint act, input longint exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   longint           m_ref [CH] = '{default: 0};
   longint           m_integ [CH] = '{default: 0};
   int               m_cnt = 0;
   bit               m_valid = 0, m_overrun = 0, m_busy_pre = 0;
   logic [CH*DW-1:0] m_data = '0, m_pend_data = '0;
   logic [CH-1:0]    m_sat = '0, m_pend_sat = '0;

   function automatic longint clampl(input longint v, input longint lim);
      if (v > lim)  return lim;
      if (v < -lim) return -lim;
      return v;
   endfunction

   function automatic void model_compute(input logic [CH*DW-1:0] meas, input longint kp, input longint ki);
      for (int k = 0; k < CH; k++) begin
         longint e, p, ic, ur, u;
         bit s;
         e  = m_ref[k] - longint'($signed(meas[k*DW +: DW]));
         p  = kp * e;
         ic = clampl(m_integ[k] + ki * e, longint'(OL) * (longint'(1) << GS));
         ur = (p + ic) >>> GS;
         u  = clampl(ur, OL);
         s  = (u != ur);
         if (!(s && e != 0 && ((e < 0) == (ur < 0)))) m_integ[k] = ic;
         m_pend_data[k*DW +: DW] = u[DW-1:0];
         m_pend_sat[k] = s;
      end
   endfunction

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_cnt = 0; m_valid = 0; m_overrun = 0; m_data = '0; m_sat = '0;
         for (int k = 0; k < CH; k++) begin m_integ[k] = 0; m_ref[k] = 0; end
      end else begin
         m_busy_pre = (m_cnt > 0) || m_valid;
         if (fault) begin
            m_cnt = 0; m_valid = 0; m_overrun = 0; m_data = '0; m_sat = '0;
            for (int k = 0; k < CH; k++) m_integ[k] = 0;
         end else begin
            m_overrun = measurement_valid && m_busy_pre;
            if (m_valid) begin
               if (output_ready) m_valid = 0;
            end else if (m_cnt > 0) begin
               m_cnt--;
               if (m_cnt == 0) begin m_valid = 1; m_data = m_pend_data; m_sat = m_pend_sat; end
            end else if (measurement_valid) begin
               model_compute(measurement_data, longint'(param_kp), longint'(param_ki));
               m_cnt = 4*CH;
            end
         end
         if (reference_valid)
            for (int k = 0; k < CH; k++) m_ref[k] = longint'($signed(reference_data[k*DW +: DW]));
      end
   end

   always @(negedge clk) begin
      if (reset_n === 1'b1) begin
         check("output_valid", output_valid, m_valid);
         check("busy", busy, (m_cnt > 0) || m_valid);
         check("overrun", overrun, m_overrun);
         check("output_data", output_data, m_data);
         check("saturated", saturated, m_sat);
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic load_ref(input longint rd, input longint rq, input longint kp, input longint ki);
      @(negedge clk);
      reference_data  = {DW'(rq), DW'(rd)};
      reference_valid = 1'b1;
      param_kp = GW'(kp);
      param_ki = GW'(ki);
      @(negedge clk);
      reference_valid = 1'b0;
   endtask

   task automatic start_meas(input longint md, input longint mq);
      measurement_data  = {DW'(mq), DW'(md)};
      measurement_valid = 1'b1;
   endtask

   task automatic wait_valid(output int lat);
      lat = 0;
      do begin
         @(negedge clk);
         measurement_valid = 1'b0;
         lat++;
      end while (!output_valid && lat < 40);
   endtask

   task automatic take(output longint od, output longint oq, output logic [CH-1:0] s);
      od = longint'($signed(output_data[DW-1:0]));
      oq = longint'($signed(output_data[2*DW-1:DW]));
      s  = saturated;
      output_ready = 1'b1;
      @(negedge clk);
      output_ready = 1'b0;
   endtask

   task automatic run_update(input longint rd, input longint rq, input longint md, input longint mq,
                             input longint kp, input longint ki,
                             output longint od, output longint oq, output logic [CH-1:0] s, output int lat);
      load_ref(rd, rq, kp, ki);
      start_meas(md, mq);
      wait_valid(lat);
      take(od, oq, s);
   endtask

   task automatic do_fault();
      @(negedge clk); fault = 1'b1;
      @(negedge clk); fault = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end

   initial begin
      longint od, oq;
      logic [CH-1:0] s;
      int lat;
      logic [CH*DW-1:0] captured;
      bit seen;
      longint integ_exp [3] = '{99, 199, 298};
      longint aw_exp [4] = '{1000, 2000, 2047, 2047};

      reset_n = 1'b0; fault = 1'b0; reference_valid = 1'b0; measurement_valid = 1'b0;
      output_ready = 1'b0; reference_data = '0; measurement_data = '0;
      param_kp = '0; param_ki = '0;
      repeat (3) @(negedge clk);
      check("rst_valid", output_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_overrun", overrun, 0);
      check("rst_data", output_data, 0);
      check("rst_sat", saturated, 0);
      reset_n = 1'b1;

      // proportional only
      run_update(0, 1000, 0, 0, 1024, 0, od, oq, s, lat);
      check("p_only_latency", lat, LAT);
      check("p_only_q", oq, 1000);
      check("p_only_d", od, 0);
      check("p_only_sat", s, 0);

      // output clamp
      run_update(0, 3000, 0, 0, 1024, 0, od, oq, s, lat);
      check("clamp_pos_q", oq, 2047);
      check("clamp_pos_sat", s, 2);
      run_update(0, -3000, 0, 0, 1024, 0, od, oq, s, lat);
      check("clamp_neg_q", oq, -2047);
      check("clamp_neg_sat", s, 2);

      // integral only
      do_fault();
      for (int i = 0; i < 3; i++) begin
         run_update(0, 1000, 0, 0, 0, 102, od, oq, s, lat);
         check("integ_q", oq, integ_exp[i]);
      end

      // anti-windup
      do_fault();
      for (int i = 0; i < 4; i++) begin
         run_update(0, 1000, 0, 0, 0, 1024, od, oq, s, lat);
         check("aw_q", oq, aw_exp[i]);
      end
      check("aw_model_integ", m_integ[1], 2096128);
      run_update(0, 0, 0, 1000, 0, 1024, od, oq, s, lat);
      check("aw_unwind_q", oq, 1047);

      // backpressure and overrun
      do_fault();
      load_ref(0, 500, 1024, 0);
      start_meas(0, 0);
      wait_valid(lat);
      check("bp_latency", lat, LAT);
      captured = output_data;
      check("bp_q", longint'($signed(captured[2*DW-1:DW])), 500);
      for (int i = 0; i < 20; i++) begin
         measurement_valid = (i == 4);
         @(negedge clk);
         check("bp_data_stable", output_data, captured);
         check("bp_busy", busy, 1);
         check("bp_valid", output_valid, 1);
         if (i == 4) check("bp_overrun_pulse", overrun, 1);
         if (i == 5) check("bp_overrun_clear", overrun, 0);
      end
      measurement_valid = 1'b0;
      output_ready = 1'b1;
      @(negedge clk);
      output_ready = 1'b0;
      check("bp_released", output_valid, 0);

      // fault mid-update
      run_update(0, 500, 0, 0, 0, 1024, od, oq, s, lat);
      check("fault_pre_q", oq, 500);
      load_ref(0, 500, 0, 1024);
      start_meas(0, 0);
      seen = 0;
      for (int l = 1; l <= 20; l++) begin
         @(negedge clk);
         measurement_valid = 1'b0;
         fault = (l == 5);
         if (output_valid) seen = 1;
      end
      fault = 1'b0;
      check("fault_no_valid", seen, 0);
      run_update(0, 500, 0, 0, 0, 1024, od, oq, s, lat);
      check("fault_post_q", oq, 500);

      // reset while a result is pending
      load_ref(0, 3000, 1024, 0);
      start_meas(0, 0);
      wait_valid(lat);
      check("rst_mid_valid_before", output_valid, 1);
      #2 reset_n = 1'b0;
      #1;
      check("rst_mid_valid", output_valid, 0);
      check("rst_mid_data", output_data, 0);
      check("rst_mid_sat", saturated, 0);
      check("rst_mid_busy", busy, 0);
      check("rst_mid_overrun", overrun, 0);
      @(negedge clk);
      reset_n = 1'b1;

      // randomized traffic against the model
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         reference_valid = ($urandom_range(7) == 0);
         reference_data  = {DW'(int'($urandom_range(6000)) - 3000), DW'(int'($urandom_range(6000)) - 3000)};
         measurement_data = {DW'(int'($urandom_range(6000)) - 3000), DW'(int'($urandom_range(6000)) - 3000)};
         measurement_valid = ($urandom_range(4) == 0);
         output_ready = ($urandom_range(2) != 0);
         fault = ($urandom_range(149) == 0);
         if (m_cnt == 0 && !m_valid && !measurement_valid && $urandom_range(3) == 0) begin
            param_kp = GW'($urandom_range(1500));
            param_ki = GW'($urandom_range(600));
         end
      end
      @(negedge clk);
      fault = 1'b0; reference_valid = 1'b0; measurement_valid = 1'b0; output_ready = 1'b1;
      repeat (20) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/dq_pi_current_controller.md
Name: dq_pi_current_controller

Overview:
- Parametrised, time-multiplexed PI current regulator for the field-oriented motor drive path.
- Takes per-axis current references (d, q, optionally more channels) and per-axis measurements, and produces saturated voltage commands for the inverse Park/PWM stage.
- Generalises the fixed two-axis regulator:
  - configurable channel count and widths;
  - one shared multiplier;
  - integrator clamp with conditional-integration anti-windup;
  - output backpressure;
  - overrun reporting.

Parameters:
- CHANNELS, 2, number of regulated axes (channel 0 = d, channel 1 = q).
- DATA_WIDTH, 16, signed width of reference, measurement and output per channel.
- GAIN_WIDTH, 16, unsigned width of param_kp and param_ki.
- GAIN_SHIFT, 10, gains are fixed-point with GAIN_SHIFT fractional bits.
- OUT_LIMIT, 2047, symmetric output clamp magnitude (must be < 2^(DATA_WIDTH-1)).

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- fault  in  1  synchronous abort; clears integrators, forces outputs to zero
- reference_data  in  CHANNELS*DATA_WIDTH  signed references, channel 0 in LSBs
- reference_valid  in  1  latch reference_data
- measurement_data  in  CHANNELS*DATA_WIDTH  signed measurements, channel 0 in LSBs
- measurement_valid  in  1  start one control update
- param_kp  in  GAIN_WIDTH  proportional gain
- param_ki  in  GAIN_WIDTH  integral gain (per update)
- output_data  out  CHANNELS*DATA_WIDTH  signed commands, channel 0 in LSBs
- output_valid  out  1  output_data valid
- output_ready  in  1  downstream accept
- saturated  out  CHANNELS  per-channel clamp flag of the last result
- busy  out  1  update in progress or result pending
- overrun  out  1  one-cycle pulse when a measurement is dropped

Behaviour:
- Reset (reset_n low, async) clears:
  - output_data, output_valid, saturated, busy, overrun to 0;
  - all integrators and reference registers to 0;
  - FSM to IDLE.
- References are held in registers.
  - reference_valid loads them in any state.
  - A running update uses the value latched at its start (snapshot on measurement_valid).
- FSM states:
  - IDLE -> ERR on measurement_valid & ~fault.
  - Per channel k: ERR -> MUL_P -> MUL_I -> ACC, then either ERR for k+1 or OUT after the last channel.
  - OUT holds output_valid=1 until output_ready; then returns to IDLE.
- Latency: output_valid rises exactly 4*CHANNELS+1 cycles after the measurement_valid cycle (9 cycles for CHANNELS=2).
- Arithmetic per channel:
  - e = ref - meas, sign-extended to DATA_WIDTH+1.
  - p = kp*e.
  - i_cand = integ + ki*e.
  - u_raw = (p + i_cand) >>> GAIN_SHIFT (arithmetic shift, floor rounding); internal widths sized so nothing overflows.
  - u = clamp(u_raw, -OUT_LIMIT, +OUT_LIMIT).
  - saturated[k] = (u != u_raw).
- Integrator update:
  - Candidate is clamped to ±(OUT_LIMIT << GAIN_SHIFT).
  - Conditional integration: the integrator is NOT updated when saturated[k] and e has the same sign as u_raw.
  - Otherwise integ <= clamped i_cand.
- Shared multiplier: exactly one GAIN_WIDTH x (DATA_WIDTH+1) signed multiply per cycle.
- output_data / saturated update together when entering OUT, and remain stable while output_valid=1 & ~output_ready.
- measurement_valid while busy=1 (computing or OUT pending): sample dropped, overrun pulses 1 cycle, state unaffected.
- fault=1 (any state, takes priority over every other event):
  - next cycle: FSM IDLE, integrators 0, output_data 0, output_valid 0, saturated 0, busy 0;
  - measurement_valid is ignored (no overrun) while fault=1.
- Simultaneous output_ready handshake and measurement_valid in the same cycle: the measurement is dropped with overrun (IDLE only reached next cycle).
- Gains are sampled at MUL_P / MUL_I of each channel; changes mid-update apply from the next multiply.
- Reset asserted mid-update: immediate return to reset state; no partial output.

Test Plan:
- P-only: kp=1024, ki=0, ref={q=1000, d=0}, meas=0.
  - Required: output q=1000, d=0.
  - output_valid exactly 9 cycles after measurement_valid.
  - saturated=00.
- Clamp: kp=1024, ki=0, ref q=3000, meas 0 -> q=2047, saturated[1]=1. Ref q=-3000 -> q=-2047.
- Integrator: kp=0, ki=102, error q=1000, three updates -> q outputs 99, 199, 298.
- Anti-windup:
  - kp=0, ki=1024, error q=1000, 4 updates -> outputs 1000, 2000, 2047, 2047; integrator held at 2096128.
  - Then error -1000 -> output 1047.
- Backpressure/overrun:
  - output_ready=0 for 20 cycles: output_data stable, busy=1.
  - Second measurement_valid during that window -> overrun 1-cycle pulse, result unchanged.
  - Then output_ready=1 -> handshake, output_valid=0 next cycle.
- Fault/reset:
  - fault pulse mid-update (cycle 5) -> no output_valid; next update with ki-only gain starts from integrator 0.
  - reset_n low mid-OUT -> all outputs 0 asynchronously.
